// File: rtl/psum_accumulator.sv
// Saturating accumulator for signed PE partial products, one group of
// (i_acc_len+1) terms at a time, with a single-entry valid/ready result register.
module psum_accumulator #(
  parameter int PROD_W = 17,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [PROD_W-1:0] i_prod,
  input  logic [CNT_W-1:0]  i_acc_len,
  input  logic              i_clear,
  output logic              o_in_ready,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_sat,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  // Returns {saturated, value}: ACC_W+1-bit add clamped to the ACC_W signed range.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W:0]   b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + b;
    if (s[ACC_W] != s[ACC_W-1]) begin
      if (s[ACC_W]) begin
        sat_add = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sat_add = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      sat_add = {1'b0, s[ACC_W-1:0]};
    end
  endfunction

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W:0]     r_cnt;
  logic               r_sat_g;
  logic [ACC_W-1:0]   r_sum;
  logic               r_sat;
  logic               r_valid;

  state_t             w_state_nxt;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   w_len_nxt;
  logic [CNT_W:0]     w_cnt_nxt;
  logic [CNT_W:0]     w_cnt_inc;
  logic               w_satg_nxt;
  logic               w_done;
  logic               w_in_ready;
  logic               w_fire;
  logic [ACC_W:0]     w_prod_ext;
  logic [ACC_W:0]     w_sat_res;

  assign w_in_ready = ~r_valid | i_ready;
  assign w_fire     = i_valid & w_in_ready & ~i_clear;
  assign w_prod_ext = {{(ACC_W+1-PROD_W){i_prod[PROD_W-1]}}, i_prod};
  assign w_sat_res  = sat_add(r_acc, w_prod_ext);

  // Next-state, accumulator and completion decode
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_cnt_inc   = r_cnt;
    w_satg_nxt  = r_sat_g;
    w_done      = 1'b0;
    if (i_clear) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = {(CNT_W+1){1'b0}};
    end else if (w_fire) begin
      case (r_state)
        S_ACC: begin
          w_acc_nxt  = w_sat_res[ACC_W-1:0];
          w_satg_nxt = r_sat_g | w_sat_res[ACC_W];
          w_cnt_inc  = r_cnt + {{CNT_W{1'b0}}, 1'b1};
        end
        default: begin
          w_acc_nxt  = w_prod_ext[ACC_W-1:0];
          w_len_nxt  = i_acc_len;
          w_satg_nxt = 1'b0;
          w_cnt_inc  = {{CNT_W{1'b0}}, 1'b1};
        end
      endcase
      // Compare at CNT_W+1 bits so a full 2^CNT_W-term group cannot wrap
      if (w_cnt_inc == ({1'b0, w_len_nxt} + {{CNT_W{1'b0}}, 1'b1})) begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {(CNT_W+1){1'b0}};
      end else begin
        w_state_nxt = S_ACC;
        w_cnt_nxt   = w_cnt_inc;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Group state and running accumulator
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= {ACC_W{1'b0}};
      r_len   <= {CNT_W{1'b0}};
      r_cnt   <= {(CNT_W+1){1'b0}};
      r_sat_g <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sat_g <= w_satg_nxt;
    end
  end

  // Result register: a completion wins over a same-cycle drain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum   <= {ACC_W{1'b0}};
      r_sat   <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_done) begin
      r_sum   <= w_acc_nxt;
      r_sat   <= w_satg_nxt;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_in_ready = w_in_ready;
  assign o_sum      = r_sum;
  assign o_sat      = r_sat;
  assign o_valid    = r_valid;
  assign o_busy     = (r_state == S_ACC);

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed cases with hand-computed results plus a
// randomized run, all checked every cycle against an integer group model.
module tb_psum_accumulator;
  localparam int PROD_W = 17;
  localparam int ACC_W  = 24;
  localparam int CNT_W  = 8;
  localparam longint AMAX = (64'sd1 <<< (ACC_W-1)) - 64'sd1;
  localparam longint AMIN = -(64'sd1 <<< (ACC_W-1));

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_valid = 1'b0;
  logic [PROD_W-1:0] i_prod = '0;
  logic [CNT_W-1:0]  i_acc_len = '0;
  logic              i_clear = 1'b0;
  logic              i_ready = 1'b1;
  logic              o_in_ready, o_sat, o_valid, o_busy;
  logic [ACC_W-1:0]  o_sum;

  int checks = 0;
  int failures = 0;

  psum_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_prod(i_prod),
    .i_acc_len(i_acc_len), .i_clear(i_clear), .o_in_ready(o_in_ready),
    .o_sum(o_sum), .o_sat(o_sat), .o_valid(o_valid), .i_ready(i_ready),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: group as integer running sum with clamping
  bit     m_open, m_satg, m_sat, m_valid;
  longint m_acc, m_sum;
  int     m_cnt, m_len;

  always @(posedge clk or negedge rst_n) begin
    automatic bit     rdy;
    automatic bit     fire;
    automatic bit     done;
    automatic bit     s;
    automatic longint a;
    automatic int     c;
    automatic int     l;
    if (!rst_n) begin
      m_open <= 1'b0; m_satg <= 1'b0; m_sat <= 1'b0; m_valid <= 1'b0;
      m_acc <= 0; m_sum <= 0; m_cnt <= 0; m_len <= 0;
    end else begin
      rdy  = !m_valid || i_ready;
      fire = i_valid && rdy && !i_clear;
      done = 1'b0;
      if (i_clear) begin
        m_open <= 1'b0;
      end else if (fire) begin
        if (!m_open) begin
          a = longint'($signed(i_prod)); l = int'(i_acc_len); c = 1; s = 1'b0;
        end else begin
          a = m_acc + longint'($signed(i_prod)); l = m_len; c = m_cnt + 1; s = m_satg;
          if (a > AMAX) begin a = AMAX; s = 1'b1; end
          if (a < AMIN) begin a = AMIN; s = 1'b1; end
        end
        done = (c == l + 1);
        m_acc <= a; m_len <= l; m_cnt <= c; m_satg <= s;
        m_open <= !done;
        if (done) begin
          m_sum <= a; m_sat <= s;
        end
      end
      if (done) m_valid <= 1'b1;
      else if (m_valid && i_ready) m_valid <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", longint'(o_valid), longint'(m_valid));
      chk("in_ready", longint'(o_in_ready), longint'(!m_valid || i_ready));
      chk("busy", longint'(o_busy), longint'(m_open));
      chk("sum", longint'($signed(o_sum)), m_sum);
      chk("sat", longint'(o_sat), longint'(m_sat));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int prod, input int len);
    i_valid   = 1'b1;
    i_prod    = PROD_W'(prod);
    i_acc_len = CNT_W'(len);
    tick();
    i_valid   = 1'b0;
  endtask

  task automatic expect_result(input string name, input longint sum, input bit sat);
    chk({name, "_valid"}, longint'(o_valid), 64'sd1);
    chk({name, "_sum"}, longint'($signed(o_sum)), sum);
    chk({name, "_sat"}, longint'(o_sat), longint'(sat));
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_sum", longint'(o_sum), 64'sd0);
    chk("rst_in_ready", longint'(o_in_ready), 64'sd1);
    chk("rst_busy", longint'(o_busy), 64'sd0);

    // Reset in mid-group
    beat(5, 0);
    expect_result("single5", 5, 1'b0);
    beat(3, 1);
    chk("open_busy", longint'(o_busy), 64'sd1);
    rst_n = 1'b0;
    #2;
    chk("midrst_sum", longint'(o_sum), 64'sd0);
    chk("midrst_valid", longint'(o_valid), 64'sd0);
    chk("midrst_busy", longint'(o_busy), 64'sd0);
    chk("midrst_sat", longint'(o_sat), 64'sd0);
    chk("midrst_in_ready", longint'(o_in_ready), 64'sd1);
    tick();
    rst_n = 1'b1;
    tick();
    beat(3, 1);
    beat(4, 0);
    expect_result("pair", 7, 1'b0);

    // Signed four-term group
    beat(100, 3); beat(-250, 0); beat(7, 0);
    chk("pre_last_valid", longint'(o_valid), 64'sd0);
    beat(-1, 0);
    expect_result("signed4", -144, 1'b0);
    tick();
    chk("pulse_end", longint'(o_valid), 64'sd0);

    // 256-term saturating group
    beat(65535, 255);
    for (int i = 1; i < 256; i++) beat(65535, 0);
    expect_result("sat256", 8388607, 1'b1);
    beat(-65536, 0);
    expect_result("after_sat", -65536, 1'b0);

    // Backpressure with a result pending
    i_ready   = 1'b0;
    i_valid   = 1'b1;
    i_prod    = PROD_W'(9);
    i_acc_len = CNT_W'(1);
    #1;
    chk("bp_in_ready", longint'(o_in_ready), 64'sd0);
    tick(); tick();
    chk("bp_busy", longint'(o_busy), 64'sd0);
    chk("bp_hold_sum", longint'($signed(o_sum)), -64'sd65536);
    i_ready = 1'b1;
    tick();
    chk("bp_drained", longint'(o_valid), 64'sd0);
    chk("bp_accepted", longint'(o_busy), 64'sd1);
    beat(9, 0);
    expect_result("bp_pair", 18, 1'b0);

    // Back-to-back single-term groups
    beat(1, 0);
    expect_result("b2b_1", 1, 1'b0);
    beat(2, 0);
    expect_result("b2b_2", 2, 1'b0);
    beat(3, 0);
    expect_result("b2b_3", 3, 1'b0);

    // Clear drops the open group and the same-cycle beat
    beat(10, 3); beat(20, 0);
    i_valid = 1'b1; i_prod = PROD_W'(99); i_clear = 1'b1;
    tick();
    i_valid = 1'b0; i_clear = 1'b0;
    chk("clr_busy", longint'(o_busy), 64'sd0);
    chk("clr_sum_kept", longint'($signed(o_sum)), 64'sd3);
    beat(5, 0);
    expect_result("after_clr", 5, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      i_clear = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) i_prod = ($urandom_range(0, 1) != 0) ? PROD_W'(65535) : PROD_W'(-65536);
      else i_prod = PROD_W'($urandom_range(0, 131071));
      if ($urandom_range(0, 15) == 0) i_acc_len = CNT_W'($urandom_range(100, 255));
      else i_acc_len = CNT_W'($urandom_range(0, 4));
      tick();
    end
    i_valid = 1'b0; i_clear = 1'b0; i_ready = 1'b1;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Accumulates the registered signed partial products from the bit-brick PE into a wider, saturating partial sum over a programmable number of terms, one group at a time. It sits directly downstream of the PE output register and upstream of the output buffer / writeback. Finished groups go out through a single-entry output register with a valid/ready handshake. Backpressure returns to the PE controller through `o_in_ready`.

## Interface
Parameters:
- `PROD_W`, 17: width of the signed product from the PE.
- `ACC_W`, 24: width of the signed accumulator and result.
- `CNT_W`, 8: width of the group-length field and term counter.

Ports:
- `i_clk`  in  1  single clock; all state updates on its rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  `i_prod` carries a product this cycle.
- `i_prod`  in  PROD_W  signed product. It arrives aligned with `i_valid`, already registered by the PE.
- `i_acc_len`  in  CNT_W  number of terms in a group, minus 1. Range is 1..2^CNT_W terms. Sampled only on the first beat of a group.
- `i_clear`  in  1  synchronous abort of the open group.
- `o_in_ready`  out  1  a beat is accepted when `i_valid & o_in_ready`.
- `o_sum`  out  ACC_W  signed group result.
- `o_sat`  out  1  saturation occurred anywhere in the group that produced `o_sum`.
- `o_valid`  out  1  `o_sum` and `o_sat` hold an unconsumed result.
- `i_ready`  in  1  downstream accepts the result when `o_valid & i_ready`.
- `o_busy`  out  1  a group is open (state ACC).

## Operation
- **States**
  - IDLE: no group open.
  - ACC: a group is open and `cnt` terms have been accepted.
- **Accept rule:** `o_in_ready = ~o_valid | i_ready`. This is combinational and applies to every beat, not only the final one.
- **First beat** (accepted in IDLE):
  - `acc <= sext(i_prod)`.
  - `len <= i_acc_len`.
  - `sat_g <= 0`.
  - `cnt <= 1`.
  - Go to ACC, unless `i_acc_len == 0`, in which case the group is complete on this beat.
- **Later beats** (accepted in ACC):
  - `acc <= sat(acc + sext(i_prod))`, with the add performed at ACC_W+1 bits.
  - Saturation limits are `+(2^(ACC_W-1)-1)` and `-2^(ACC_W-1)`.
  - When the add saturates, `sat_g` sets sticky.
  - `cnt` increments.
- **Completion:** the group completes on the accepted beat where the term count reaches `len+1`. On that edge:
  - `o_sum` receives the final accumulated value, including that beat.
  - `o_sat` receives `sat_g`, ORed with saturation on that beat.
  - `o_valid <= 1`.
  - Return to IDLE.
- **Output drain:** `o_valid` clears on `o_valid & i_ready` unless a new completion occurs in the same cycle. A new completion overwrites the output register and `o_valid` stays 1.
- **Clear:** `i_clear` returns the block to IDLE and drops any beat presented in the same cycle, even if `o_in_ready` is high. It has no effect on `o_sum`, `o_sat` or `o_valid`.
- **Width rule:** the counter compares against `len` at CNT_W+1 bits, so `len = 2^CNT_W - 1` (256 terms) completes correctly without wrap-around.
- **Idle cycles:** cycles with `i_valid = 0` inside a group change nothing. Groups may be sparse.

## Timing
- **Reset values:**
  - `o_sum = 0`, `o_sat = 0`, `o_valid = 0`, `o_busy = 0`.
  - `o_in_ready = 1`.
  - Internally: state IDLE, `acc = 0`, `cnt = 0`.
  - A reset in mid-group discards the group.
- **Latency:** the final beat accepted at edge t gives `o_valid = 1` after edge t, with the complete sum.
- **Throughput:** one beat per cycle. The first beat of the next group may be accepted in the cycle right after a completion. A single-term group stream produces one result per cycle while `i_ready = 1`.
- **Backpressure:** while `o_valid & ~i_ready`, `o_in_ready = 0` and no beat is accepted, including non-final beats. `acc` and `cnt` hold.
- **Same-cycle drain and completion:** when `i_ready` drains the result in the same cycle that a final beat is accepted, the new result is loaded and `o_valid` stays high. No bubble is allowed.

## Test plan
- **Reset:** assert `i_rst_n = 0` mid-group → all outputs are 0 and `o_in_ready = 1`. After release, a fresh group of 2 terms `{3, 4}` returns `o_sum = 7`.
- **Signed 4-term group:** `i_acc_len = 3`, beats `{100, -250, 7, -1}`, `i_ready = 1` → `o_sum = -144` and `o_sat = 0`, with `o_valid` pulsing one cycle after the 4th beat.
- **Saturation:** `i_acc_len = 255` with 256 beats of 65535 → `o_sum = 8388607` and `o_sat = 1`. The next group of `{-65536}` gives `o_sum = -65536` and `o_sat = 0`.
- **Backpressure:**
  - `i_ready = 0` with a result pending → `o_in_ready = 0` and the beats `{9, 9}` presented are not accepted.
  - Raise `i_ready` → the pending result drains and the beats are then accepted.
- **Back-to-back single terms:** `i_acc_len = 0`, beats `{1, 2, 3}` on consecutive cycles with `i_ready = 1` → `o_sum` is 1, 2, 3 on consecutive cycles, with `o_valid` continuous.
- **Clear:**
  - Open a group of length 4 with `{10, 20}`, then assert `i_clear` with `i_valid = 1` and `i_prod = 99` → the block returns to IDLE and 99 is dropped.
  - A new group of 1 term `{5}` then gives `o_sum = 5`.
